// File: rtl/usb_ep_pkg.sv
// Shared types and constants for the USB endpoint scheduler slice.
package usb_ep_pkg;

    localparam int DEF_DEPTH   = 64;
    localparam int DEF_MAX_PKT = 64;
    localparam int EP_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2
    } state_t;

endpackage

// File: rtl/ep_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module ep_fifo #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [7:0]    wdat,
    input  logic          rd,
    output logic [7:0]    rdat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Strobes against a full or empty FIFO are dropped here, so callers need no guard.
    assign push  = wr && !full;
    assign pop   = rd && !empty;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdat  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is not reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

endmodule

// File: rtl/usb_ep_scheduler.sv
// Bridges USB IN/OUT transactions to per-endpoint IN and OUT byte FIFOs.
module usb_ep_scheduler
    import usb_ep_pkg::*;
#(
    parameter int NUM_EP  = 2,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MAX_PKT = DEF_MAX_PKT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EP_W-1:0]        endpt,
    input  logic                   txact,
    input  logic                   txpop,
    output logic                   txval,
    output logic                   txcork,
    output logic [7:0]             txdat,
    output logic [11:0]            txdat_len,
    input  logic                   rxact,
    input  logic                   rxval,
    input  logic [7:0]             rxdat,
    output logic                   rxrdy,
    input  logic [NUM_EP-1:0]      in_wr,
    input  logic [NUM_EP-1:0][7:0] in_dat,
    output logic [NUM_EP-1:0]      in_full,
    input  logic [NUM_EP-1:0]      out_rd,
    output logic [NUM_EP-1:0][7:0] out_dat,
    output logic [NUM_EP-1:0]      out_empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                   state;
    logic [EP_W-1:0]          ep_q;
    logic [11:0]              sent_q;
    logic [11:0]              txlen_q;
    logic                     txcork_q;

    logic [NUM_EP-1:0]        in_empty, in_full_w, in_pop;
    logic [NUM_EP-1:0][7:0]   in_head;
    logic [NUM_EP-1:0][CW-1:0] in_count, out_count;
    logic [NUM_EP-1:0]        out_full, out_empty_w, out_push;

    logic                     endpt_ok;
    logic                     sel_empty;
    logic [11:0]              sel_len;
    logic [7:0]               q_head;
    logic                     q_out_full;
    logic                     tx_live;
    logic                     tx_pop;
    logic                     rx_push;
    logic                     unused_out_count;

    assign endpt_ok = (endpt != '0) && (int'(endpt) <= NUM_EP);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel_empty  = 1'b1;
        sel_len    = '0;
        q_head     = '0;
        q_out_full = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (endpt == EP_W'(i + 1)) begin
                sel_empty = in_empty[i];
                sel_len   = (12'(in_count[i]) > 12'(MAX_PKT)) ? 12'(MAX_PKT) : 12'(in_count[i]);
            end
            if (ep_q == EP_W'(i + 1)) begin
                q_head     = in_head[i];
                q_out_full = out_full[i];
            end
        end
    end

    assign tx_live = (state == ST_TX) && (sent_q < txlen_q);
    assign tx_pop  = tx_live && txpop;
    assign rx_push = (state == ST_RX) && rxact && rxval && !q_out_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ep_q     <= '0;
            sent_q   <= '0;
            txlen_q  <= '0;
            txcork_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // RX is checked first so a simultaneous OUT token wins.
                    if (rxact && endpt_ok) begin
                        state <= ST_RX;
                        ep_q  <= endpt;
                    end else if (txact && endpt_ok) begin
                        state    <= ST_TX;
                        ep_q     <= endpt;
                        sent_q   <= '0;
                        txlen_q  <= sel_len;
                        txcork_q <= sel_empty;
                    end
                end
                ST_TX: begin
                    if (!txact) begin
                        state  <= ST_IDLE;
                        ep_q   <= '0;
                        sent_q <= '0;
                    end else if (tx_pop) begin
                        sent_q <= sent_q + 1'b1;
                    end
                end
                ST_RX: begin
                    if (!rxact) begin
                        state <= ST_IDLE;
                        ep_q  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        txval     = 1'b0;
        txcork    = 1'b1;
        txdat     = '0;
        txdat_len = '0;
        rxrdy     = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    txcork    = !endpt_ok || sel_empty;
                    txdat_len = endpt_ok ? sel_len : 12'd0;
                    // Tokens for unknown endpoints are absorbed without stalling the core.
                    rxrdy     = rxact && !endpt_ok;
                end
                ST_TX: begin
                    txcork    = txcork_q;
                    txdat_len = txlen_q;
                    txval     = tx_live;
                    txdat     = tx_live ? q_head : 8'd0;
                end
                ST_RX: rxrdy = !q_out_full;
                default: ;
            endcase
        end
    end

    assign in_full   = rst ? '0 : in_full_w;
    assign out_empty = rst ? '1 : out_empty_w;

    // OUT occupancy is only needed for full/empty, which the FIFO already provides.
    assign unused_out_count = ^out_count;

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        assign in_pop[i]   = tx_pop  && (ep_q == EP_W'(i + 1));
        assign out_push[i] = rx_push && (ep_q == EP_W'(i + 1));

        ep_fifo #(.DEPTH(DEPTH)) u_in_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (in_wr[i]),
            .wdat  (in_dat[i]),
            .rd    (in_pop[i]),
            .rdat  (in_head[i]),
            .count (in_count[i]),
            .full  (in_full_w[i]),
            .empty (in_empty[i])
        );

        ep_fifo #(.DEPTH(DEPTH)) u_out_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (out_push[i]),
            .wdat  (rxdat),
            .rd    (out_rd[i]),
            .rdat  (out_dat[i]),
            .count (out_count[i]),
            .full  (out_full[i]),
            .empty (out_empty_w[i])
        );
    end

endmodule

// File: tb/tb_usb_ep_scheduler.sv
// Randomized self-checking bench for usb_ep_scheduler against a queue-based endpoint model.
module tb_usb_ep_scheduler;

    localparam int NUM_EP  = 2;
    localparam int DEPTH   = 64;
    localparam int MAX_PKT = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [3:0]             endpt;
    logic                   txact, txpop, txval, txcork;
    logic [7:0]             txdat;
    logic [11:0]            txdat_len;
    logic                   rxact, rxval, rxrdy;
    logic [7:0]             rxdat;
    logic [NUM_EP-1:0]      in_wr, in_full, out_rd, out_empty;
    logic [NUM_EP-1:0][7:0] in_dat, out_dat;

    // Model: one byte queue per endpoint and direction, index 1..NUM_EP.
    logic [7:0] in_q  [NUM_EP+1][$];
    logic [7:0] out_q [NUM_EP+1][$];

    int tests = 0;
    int fails = 0;

    usb_ep_scheduler #(.NUM_EP(NUM_EP), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk       (clk),
        .rst       (rst),
        .endpt     (endpt),
        .txact     (txact),
        .txpop     (txpop),
        .txval     (txval),
        .txcork    (txcork),
        .txdat     (txdat),
        .txdat_len (txdat_len),
        .rxact     (rxact),
        .rxval     (rxval),
        .rxdat     (rxdat),
        .rxrdy     (rxrdy),
        .in_wr     (in_wr),
        .in_dat    (in_dat),
        .in_full   (in_full),
        .out_rd    (out_rd),
        .out_dat   (out_dat),
        .out_empty (out_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ep_ok(int ep);
        return (ep >= 1) && (ep <= NUM_EP);
    endfunction

    function automatic int exp_len_of(int ep);
        int n;
        if (!ep_ok(ep)) return 0;
        n = in_q[ep].size();
        return (n > MAX_PKT) ? MAX_PKT : n;
    endfunction

    task automatic user_write(int ep, logic [7:0] b);
        bit exp_full;
        exp_full = (in_q[ep].size() == DEPTH);
        tests++;
        if (in_full[ep-1] !== exp_full) begin
            fails++;
            $display("FAIL in_full ep%0d: got %b want %b", ep, in_full[ep-1], exp_full);
        end
        in_wr[ep-1]  = 1'b1;
        in_dat[ep-1] = b;
        tick();
        in_wr = '0;
        if (!exp_full) in_q[ep].push_back(b);
    endtask

    // One complete IN transaction on endpoint ep, with random core back-pressure.
    task automatic run_in(int ep);
        int  len, sent, extra, budget;
        bit  cork, exp_val;
        len  = exp_len_of(ep);
        cork = !ep_ok(ep) || (in_q[ep_ok(ep) ? ep : 1].size() == 0);
        endpt = 4'(ep); txact = 1'b1; txpop = 1'b0;
        #1;
        tests++;
        if (txcork !== cork || txdat_len !== 12'(len) || txval !== 1'b0) begin
            fails++;
            $display("FAIL in_token ep%0d: cork/len/val got %b/%0d/%b want %b/%0d/0",
                     ep, txcork, txdat_len, txval, cork, len);
        end
        tick();
        sent = 0; extra = 0; budget = 0;
        while (extra < 2) begin
            if (budget++ > 1000) begin
                fails++;
                $display("FAIL in_timeout ep%0d: sent %0d want %0d", ep, sent, len);
                break;
            end
            exp_val = ep_ok(ep) && (sent < len);
            txpop = exp_val ? 1'($urandom_range(0, 1)) : 1'b1;
            tests++;
            if (txval !== exp_val || txdat_len !== 12'(len) || txcork !== cork) begin
                fails++;
                $display("FAIL in_hold ep%0d byte %0d: val/len/cork got %b/%0d/%b want %b/%0d/%b",
                         ep, sent, txval, txdat_len, txcork, exp_val, len, cork);
            end
            if (exp_val) begin
                tests++;
                if (txdat !== in_q[ep][0]) begin
                    fails++;
                    $display("FAIL in_data ep%0d byte %0d: got %h want %h", ep, sent, txdat, in_q[ep][0]);
                end
            end
            tick();
            if (exp_val && txpop) begin
                void'(in_q[ep].pop_front());
                sent++;
            end else if (!exp_val) begin
                extra++;
            end
        end
        txpop = 1'b0; txact = 1'b0;
        tick();
    endtask

    // One OUT transaction of n random bytes; optionally the user drains concurrently.
    task automatic run_out(int ep, int n, bit rd_rand);
        bit exp_rdy, rd, had;
        endpt = 4'(ep); rxact = 1'b1; rxval = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            rxdat = 8'($urandom);
            rxval = 1'b1;
            rd    = ep_ok(ep) && rd_rand && ($urandom_range(0, 2) == 0);
            if (ep_ok(ep)) out_rd[ep-1] = rd;
            exp_rdy = ep_ok(ep) ? (out_q[ep].size() < DEPTH) : 1'b1;
            had     = ep_ok(ep) && (out_q[ep].size() != 0);
            #1;
            tests++;
            if (rxrdy !== exp_rdy) begin
                fails++;
                $display("FAIL rxrdy ep%0d byte %0d: got %b want %b", ep, i, rxrdy, exp_rdy);
            end
            if (rd && had) begin
                tests++;
                if (out_dat[ep-1] !== out_q[ep][0]) begin
                    fails++;
                    $display("FAIL out_fwft ep%0d: got %h want %h", ep, out_dat[ep-1], out_q[ep][0]);
                end
            end
            tick();
            out_rd = '0;
            if (rd && had) void'(out_q[ep].pop_front());
            if (ep_ok(ep) && exp_rdy) out_q[ep].push_back(rxdat);
        end
        rxval = 1'b0; rxact = 1'b0;
        tick();
    endtask

    task automatic drain_out(int ep, int max);
        for (int k = 0; k < max && out_q[ep].size() != 0; k++) begin
            tests++;
            if (out_empty[ep-1] !== 1'b0 || out_dat[ep-1] !== out_q[ep][0]) begin
                fails++;
                $display("FAIL out_read ep%0d: empty/dat got %b/%h want 0/%h",
                         ep, out_empty[ep-1], out_dat[ep-1], out_q[ep][0]);
            end
            out_rd[ep-1] = 1'b1;
            tick();
            out_rd = '0;
            void'(out_q[ep].pop_front());
        end
        if (out_q[ep].size() == 0) begin
            out_rd[ep-1] = 1'b1;
            tick();
            out_rd = '0;
            tests++;
            if (out_empty[ep-1] !== 1'b1) begin
                fails++;
                $display("FAIL out_empty ep%0d: got %b want 1", ep, out_empty[ep-1]);
            end
        end
    endtask

    task automatic check_reset_outputs(string tag);
        tests++;
        if (txval !== 1'b0 || txcork !== 1'b1 || txdat !== 8'h00 || txdat_len !== 12'd0 ||
            rxrdy !== 1'b0 || in_full !== '0 || out_empty !== '1) begin
            fails++;
            $display("FAIL %s: val/cork/dat/len/rdy/full/empty got %b/%b/%h/%0d/%b/%b/%b want 0/1/00/0/0/00/11",
                     tag, txval, txcork, txdat, txdat_len, rxrdy, in_full, out_empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; endpt = '0; txact = 0; txpop = 0; rxact = 0; rxval = 0; rxdat = '0;
        in_wr = '0; in_dat = '0; out_rd = '0;
        tick(); tick();
        check_reset_outputs("reset_during");
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_after");
    endtask

    task automatic test_in_basic();
        user_write(1, 8'hA1); user_write(1, 8'hA2); user_write(1, 8'hA3);
        endpt = 4'd1; #1;
        tests++;
        if (txdat_len !== 12'd3 || txcork !== 1'b0) begin
            fails++;
            $display("FAIL in_basic_len: len/cork got %0d/%b want 3/0", txdat_len, txcork);
        end
        run_in(1);
        endpt = 4'd1; #1;
        tests++;
        if (txdat_len !== 12'd0 || txcork !== 1'b1) begin
            fails++;
            $display("FAIL in_basic_empty: len/cork got %0d/%b want 0/1", txdat_len, txcork);
        end
    endtask

    task automatic test_in_split();
        for (int i = 0; i < DEPTH; i++) user_write(2, 8'($urandom));
        user_write(2, 8'hEE);
        endpt = 4'd2; #1;
        tests++;
        if (txdat_len !== 12'd64) begin
            fails++;
            $display("FAIL in_split_first: len got %0d want 64", txdat_len);
        end
        run_in(2);
        for (int i = 0; i < 36; i++) user_write(2, 8'($urandom));
        endpt = 4'd2; #1;
        tests++;
        if (txdat_len !== 12'd36) begin
            fails++;
            $display("FAIL in_split_second: len got %0d want 36", txdat_len);
        end
        run_in(2);
    endtask

    task automatic test_in_cork();
        run_in(1);
        run_in(5);
        run_in(0);
    endtask

    task automatic test_out_overflow();
        run_out(1, 70, 1'b0);
        tests++;
        if (out_q[1].size() != 64) begin
            fails++;
            $display("FAIL out_overflow_count: got %0d want 64", out_q[1].size());
        end
        drain_out(1, 100);
        run_out(3, 4, 1'b0);
        drain_out(2, 10);
    endtask

    task automatic test_collision();
        user_write(2, 8'h5A);
        endpt = 4'd2; txact = 1'b1; rxact = 1'b1; txpop = 1'b1;
        tick();
        rxval = 1'b1; rxdat = 8'hC3;
        #1;
        tests++;
        if (rxrdy !== 1'b1 || txval !== 1'b0) begin
            fails++;
            $display("FAIL collision_rx: rdy/val got %b/%b want 1/0", rxrdy, txval);
        end
        tick();
        out_q[2].push_back(8'hC3);
        rxval = 1'b0; rxact = 1'b0; txact = 1'b0; txpop = 1'b0;
        tick();
        tests++;
        if (out_empty[1] !== 1'b0 || out_dat[1] !== 8'hC3 || txdat_len !== 12'd1) begin
            fails++;
            $display("FAIL collision_store: empty/dat/len got %b/%h/%0d want 0/c3/1",
                     out_empty[1], out_dat[1], txdat_len);
        end
        drain_out(2, 4);
        run_in(2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) user_write(1, 8'(8'h10 + i));
        run_out(2, 1, 1'b0);
        endpt = 4'd1; txact = 1'b1;
        tick();
        txpop = 1'b1;
        tick(); tick();
        txpop = 1'b0; txact = 1'b0; rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_during");
        tick();
        rst = 1'b0;
        for (int e = 0; e <= NUM_EP; e++) begin
            in_q[e].delete();
            out_q[e].delete();
        end
        #1;
        tests++;
        if (txcork !== 1'b1 || txdat_len !== 12'd0 || txval !== 1'b0 || in_full !== '0 || out_empty !== '1) begin
            fails++;
            $display("FAIL reset_mid_after: cork/len/val/full/empty got %b/%0d/%b/%b/%b want 1/0/0/00/11",
                     txcork, txdat_len, txval, in_full, out_empty);
        end
        run_in(1);
    endtask

    task automatic test_random();
        int op, ep;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            ep = $urandom_range(1, NUM_EP);
            case (op)
                0: for (int i = $urandom_range(1, 40); i > 0; i--) user_write(ep, 8'($urandom));
                1: run_in($urandom_range(0, 3));
                2: run_out($urandom_range(0, 3), $urandom_range(1, 30), 1'b1);
                default: drain_out(ep, $urandom_range(1, 30));
            endcase
        end
        for (int e = 1; e <= NUM_EP; e++) begin
            drain_out(e, DEPTH + 1);
            while (in_q[e].size() != 0) run_in(e);
            run_in(e);
        end
    endtask

    initial begin
        test_reset();
        test_in_basic();
        test_in_split();
        test_in_cork();
        test_out_overflow();
        test_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
